// File: rtl/ram_sequencer.sv
// Command sequencer for the FRANK6000 RAM. Handles single READ/WRITE and block
// COPY/FILL commands, and accounts for the RAM's one-cycle registered read port.
module ram_sequencer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    input  logic [ADDR_WIDTH-1:0] i_len,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_done,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_we,
    output logic                  o_ram_re,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_CAP,
        S_WR,
        S_CP_RD,
        S_CP_WR,
        S_FILL,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_a_q, ptr_a_d;     // READ/WRITE address, COPY source, FILL destination
    logic [ADDR_WIDTH-1:0]   ptr_b_q, ptr_b_d;     // COPY destination
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;         // words still to be written
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    done_q, done_d;
    logic                    last_word;

    // Block terminates on the word that brings the count to zero; a zero count also ends it
    assign last_word = (cnt_q == ADDR_WIDTH'(1)) || (cnt_q == '0);

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ptr_a_q     <= '0;
            ptr_b_q     <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_a_q     <= ptr_a_d;
            ptr_b_q     <= ptr_b_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
        end
    end

    // Next-state, operand capture and completion pulses
    always_comb begin
        state_d     = state_q;
        ptr_a_d     = ptr_a_q;
        ptr_b_d     = ptr_b_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    ptr_a_d = i_addr_a;
                    ptr_b_d = i_addr_b;
                    cnt_d   = i_len;
                    wdata_d = i_wdata;
                    case (i_cmd_op)
                        OP_READ:  state_d = S_RD;
                        OP_WRITE: state_d = S_WR;
                        OP_COPY:  state_d = (i_len == '0) ? S_DONE : S_CP_RD;
                        OP_FILL:  state_d = (i_len == '0) ? S_DONE : S_FILL;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_RD: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                rsp_data_d  = i_ram_data;
                rsp_valid_d = 1'b1;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            S_WR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_CP_RD: begin
                state_d = S_CP_WR;
            end
            S_CP_WR: begin
                ptr_a_d = ptr_a_q + ADDR_WIDTH'(1);
                ptr_b_d = ptr_b_q + ADDR_WIDTH'(1);
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - ADDR_WIDTH'(1);
                if (last_word) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CP_RD;
                end
            end
            S_FILL: begin
                ptr_a_d = ptr_a_q + ADDR_WIDTH'(1);
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - ADDR_WIDTH'(1);
                if (last_word) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // RAM pin decode from state; copy write data passes straight from the RAM read port
    always_comb begin
        o_ram_addr = '0;
        o_ram_data = '0;
        o_ram_we   = 1'b0;
        o_ram_re   = 1'b0;
        case (state_q)
            S_RD, S_CP_RD: begin
                o_ram_re   = 1'b1;
                o_ram_addr = ptr_a_q;
            end
            S_WR, S_FILL: begin
                o_ram_we   = 1'b1;
                o_ram_addr = ptr_a_q;
                o_ram_data = wdata_q;
            end
            S_CP_WR: begin
                o_ram_we   = 1'b1;
                o_ram_addr = ptr_b_q;
                o_ram_data = i_ram_data;
            end
            default: begin
                o_ram_we   = 1'b0;
            end
        endcase
    end

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed bench for ram_sequencer with a behavioural registered-read RAM.
module tb_ram_sequencer;

    logic       i_clk;
    logic       i_rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [1:0] i_cmd_op;
    logic [7:0] i_addr_a;
    logic [7:0] i_addr_b;
    logic [7:0] i_len;
    logic [7:0] i_wdata;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_data;
    logic       o_done;
    logic       o_busy;
    logic [7:0] o_ram_addr;
    logic [7:0] o_ram_data;
    logic       o_ram_we;
    logic       o_ram_re;
    logic [7:0] i_ram_data;

    logic [7:0] mem [0:255];

    int n_cmp;
    int n_err;
    int we_cnt;
    int re_cnt;
    int overlap_cnt;
    int idle_bus_cnt;
    int edges;

    ram_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_addr_a    (i_addr_a),
        .i_addr_b    (i_addr_b),
        .i_len       (i_len),
        .i_wdata     (i_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_ram_addr  (o_ram_addr),
        .o_ram_data  (o_ram_data),
        .o_ram_we    (o_ram_we),
        .o_ram_re    (o_ram_re),
        .i_ram_data  (i_ram_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // RAM model: synchronous write, registered read
    always @(posedge i_clk) begin
        if (o_ram_we) mem[o_ram_addr] <= o_ram_data;
        if (o_ram_re) i_ram_data <= mem[o_ram_addr];
    end

    // Strobe monitor, sampled mid-cycle
    always @(negedge i_clk) begin
        if (o_ram_we) we_cnt++;
        if (o_ram_re) re_cnt++;
        if (o_ram_we && o_ram_re) overlap_cnt++;
        if (!o_ram_we && !o_ram_re && (o_ram_addr != 8'h00 || o_ram_data != 8'h00)) idle_bus_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command from a negedge; returns edges from accept to the o_done cycle
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] len, input logic [7:0] wd, output int n);
        int guard;
        guard = 0;
        while (!o_cmd_ready && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        check("ready_before_cmd", 32'(o_cmd_ready), 32'd1);
        we_cnt      = 0;
        re_cnt      = 0;
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_addr_a    = a;
        i_addr_b    = b;
        i_len       = len;
        i_wdata     = wd;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        i_addr_a    = 8'h5A;
        i_addr_b    = 8'hC3;
        i_len       = 8'h77;
        i_wdata     = 8'hEE;
        n = 0;
        @(negedge i_clk);
        while (!o_done && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        run_cmd(2'b01, a, 8'h00, 8'h00, d, edges);
        check("write_latency", 32'(edges), 32'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
        run_cmd(2'b00, a, 8'h00, 8'h00, 8'h00, edges);
        check("read_latency", 32'(edges), 32'd2);
        check("read_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("read_data", 32'(o_rsp_data), 32'(exp));
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        we_cnt       = 0;
        re_cnt       = 0;
        overlap_cnt  = 0;
        idle_bus_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        i_ram_data  = 8'h00;
        i_rst       = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'b00;
        i_addr_a    = 8'h00;
        i_addr_b    = 8'h00;
        i_len       = 8'h00;
        i_wdata     = 8'h00;
        repeat (3) @(negedge i_clk);

        // Reset state
        check("rst_ready", 32'(o_cmd_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(o_rsp_data), 32'd0);
        check("rst_ram_we", 32'(o_ram_we), 32'd0);
        check("rst_ram_re", 32'(o_ram_re), 32'd0);
        check("rst_ram_addr", 32'(o_ram_addr), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // WRITE then READ
        do_write(8'h10, 8'hA5);
        check("write_we_cycles", 32'(we_cnt), 32'd1);
        check("write_mem", 32'(mem[8'h10]), 32'hA5);
        do_read(8'h10, 8'hA5);
        check("read_re_cycles", 32'(re_cnt), 32'd1);
        check("read_ready", 32'(o_cmd_ready), 32'd1);
        @(negedge i_clk);
        check("rsp_valid_pulse", 32'(o_rsp_valid), 32'd0);
        check("done_pulse", 32'(o_done), 32'd0);
        check("rsp_data_held", 32'(o_rsp_data), 32'hA5);

        // FILL wrapping past the top address
        run_cmd(2'b11, 8'hFE, 8'h00, 8'd4, 8'h3C, edges);
        check("fill_latency", 32'(edges), 32'd4);
        check("fill_we_cycles", 32'(we_cnt), 32'd4);
        check("fill_re_cycles", 32'(re_cnt), 32'd0);
        check("fill_no_rsp", 32'(o_rsp_valid), 32'd0);
        do_read(8'hFE, 8'h3C);
        do_read(8'hFF, 8'h3C);
        do_read(8'h00, 8'h3C);
        do_read(8'h01, 8'h3C);
        check("fill_stop", 32'(mem[8'h02]), 32'h00);

        // Non-overlapping COPY
        do_write(8'h20, 8'd1);
        do_write(8'h21, 8'd2);
        do_write(8'h22, 8'd3);
        run_cmd(2'b10, 8'h20, 8'h40, 8'd3, 8'h00, edges);
        check("copy_latency", 32'(edges), 32'd6);
        check("copy_we_cycles", 32'(we_cnt), 32'd3);
        check("copy_re_cycles", 32'(re_cnt), 32'd3);
        do_read(8'h40, 8'd1);
        do_read(8'h41, 8'd2);
        do_read(8'h42, 8'd3);
        check("copy_dst_stop", 32'(mem[8'h43]), 32'h00);
        do_read(8'h20, 8'd1);
        do_read(8'h22, 8'd3);

        // Overlapping forward COPY replicates the first word
        do_write(8'h20, 8'd7);
        run_cmd(2'b10, 8'h20, 8'h21, 8'd3, 8'h00, edges);
        check("ovl_latency", 32'(edges), 32'd6);
        do_read(8'h21, 8'd7);
        do_read(8'h22, 8'd7);
        do_read(8'h23, 8'd7);

        // Zero-length COPY and FILL
        run_cmd(2'b10, 8'h20, 8'h60, 8'd0, 8'h00, edges);
        check("copy0_latency", 32'(edges), 32'd1);
        check("copy0_we", 32'(we_cnt), 32'd0);
        check("copy0_re", 32'(re_cnt), 32'd0);
        check("copy0_ready", 32'(o_cmd_ready), 32'd1);
        run_cmd(2'b11, 8'h60, 8'h00, 8'd0, 8'h55, edges);
        check("fill0_latency", 32'(edges), 32'd1);
        check("fill0_we", 32'(we_cnt), 32'd0);
        check("fill0_mem", 32'(mem[8'h60]), 32'h00);

        // Reset during FILL after three committed writes
        @(negedge i_clk);
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'b11;
        i_addr_a    = 8'h80;
        i_len       = 8'd8;
        i_wdata     = 8'h99;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        repeat (4) @(negedge i_clk);
        check("midfill_we_before", 32'(o_ram_we), 32'd1);
        i_rst = 1'b1;
        #1;
        check("abort_we", 32'(o_ram_we), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_ready", 32'(o_cmd_ready), 32'd1);
        check("abort_addr", 32'(o_ram_addr), 32'd0);
        check("abort_rsp_data", 32'(o_rsp_data), 32'd0);
        @(negedge i_clk);
        check("abort_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("abort_done_after", 32'(o_done), 32'd0);
        check("abort_mem80", 32'(mem[8'h80]), 32'h99);
        check("abort_mem82", 32'(mem[8'h82]), 32'h99);
        check("abort_mem83", 32'(mem[8'h83]), 32'h00);
        do_read(8'h81, 8'h99);
        do_read(8'h83, 8'h00);

        // Bus-wide invariants
        check("we_re_overlap", 32'(overlap_cnt), 32'd0);
        check("idle_bus_nonzero", 32'(idle_bus_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
